rf_seq_ctrl: RTL
================

Name: rf_seq_ctrl

Overview:
Sequencing controller for the 4-entry x 9-bit register file and its ALU. Accepts one encoded instruction at a time over a valid/ready handshake. Drives the register file's read and write ports and the ALU opcode through a fixed READ/EXEC/WRITE sequence. Reports completion and keeps a retired-instruction count. Sits between the host (switch/test driver) and the register-file + ALU datapath.

Parameters:
DATA_W, 9, register/ALU data width
ADDR_W, 2, register address width (2**ADDR_W registers)
CNT_W, 8, width of retired-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
instr_valid  in  1  host presents instruction
instr_ready  out  1  controller can accept instruction
instr  in  9  {opcode[8:6], rd[5:4], rs0[3:2], rs1[1:0]}
imm  in  DATA_W  immediate for LDI, sampled with instr
alu_result  in  DATA_W  combinational ALU output for current rf data and alu_op
rf_rd0_addr  out  ADDR_W  register file read port 0 address
rf_rd1_addr  out  ADDR_W  register file read port 1 address
rf_wr_addr  out  ADDR_W  register file write address
rf_wr_en  out  1  register file write enable
rf_wr_data  out  DATA_W  register file write data
alu_op  out  3  ALU operation select
busy  out  1  instruction in flight
done  out  1  one-cycle pulse, instruction retired
retired_cnt  out  CNT_W  instructions retired since reset, wraps

Behaviour:
- Opcodes: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 NOT (rs0 only, rs1 ignored), 111 LDI (rd <= imm). All eight opcodes are legal.
- Accept: handshake fires on a rising edge with instr_valid & instr_ready. instr and imm are latched into internal registers. The host may change instr/imm after the accept edge.
- instr_ready = 1 only in IDLE. busy = !instr_ready.
- FSM states: IDLE, READ, EXEC, WRITE.
  - IDLE + accept: ALU op -> READ; LDI -> WRITE; NOP -> IDLE with done.
  - READ -> EXEC. Drives rf_rd0_addr=rs0, rf_rd1_addr=rs1. Register file read data is valid one cycle after the address.
  - EXEC -> WRITE. Addresses held, alu_op = opcode, and alu_result is captured into result_q at the end of EXEC.
  - WRITE -> IDLE. rf_wr_en=1 for exactly one cycle, rf_wr_addr=rd, rf_wr_data = result_q for ALU ops or latched imm for LDI.
- alu_op = latched opcode in READ, EXEC and WRITE; 000 otherwise.
- Read addresses hold their last value outside READ/EXEC.
- rf_wr_en = 0 in every state except WRITE. rf_wr_data = 0 when rf_wr_en = 0.
- done is registered: high for one cycle in the IDLE cycle after WRITE, or the cycle after a NOP is accepted. retired_cnt increments on the same edge that raises done. NOP counts. Count wraps 2**CNT_W-1 -> 0.
- Latency, accept edge to done high:
  - ALU op: 4 cycles, rf write on 3rd cycle after accept.
  - LDI: 2 cycles.
  - NOP: 1 cycle.
- Back-to-back: ready is high during the done cycle, so a new instruction may be accepted there. Throughput is one ALU op per 4 cycles.
- rd equal to rs0/rs1 is legal. Operands are read before the write, so there is no hazard.
- Reset (any state, mid-operation):
  - state <- IDLE; latched instr, imm and result_q <- 0.
  - rf_wr_en, done, alu_op, all addresses, rf_wr_data <- 0; retired_cnt <- 0.
  - An in-flight instruction is discarded with no write, and instr_valid is ignored during the rst cycle.
- The register file is not cleared by this block; its own reset covers that.

Decomposition:
- Shared package rf_pkg: opcode constants (OP_NOP..OP_LDI), instruction field offsets, state enum encoding, DATA_W/ADDR_W defaults.
- Single module. The instruction decoder (opcode -> next state, uses_rs1) is a natural small sub-module rf_instr_dec, but it is optional.

Test Plan:
- After rst, LDI r1,imm=9'h005 then LDI r2,imm=9'h003 -> rf_wr_en pulses with (addr1,005), (addr2,003); done 2 cycles after each accept; retired_cnt=2.
- With r1=5, r2=3, ADD r3,r1,r2 -> rd0=1/rd1=2 in READ, alu_op=001 in READ..WRITE, write (3, 9'h008) on 3rd cycle, done on 4th.
- SUB r0,r2,r1 (3-5) -> write (0, 9'h1FE), confirming 9-bit wrap. NOT r0,r0 -> write 9'h001. rd==rs handled.
- instr_valid held high with NOP, ADD, LDI streamed -> accepts only when ready; done cycles back-to-back legal; retired_cnt=3; no extra writes.
- Assert rst during EXEC of ADD r3 -> no rf_wr_en that op; all outputs 0 next cycle; ready=1; retired_cnt=0.
- 256 NOPs with CNT_W=8 -> retired_cnt wraps to 0; 255 done pulses observed before wrap plus 1 at wrap.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file sequencing controller.
// Holds the default datapath widths, the opcode encodings, the bit
// positions of the fields inside the 9-bit instruction word and the
// controller state encoding.
package rf_pkg;

    // Default datapath geometry
    localparam int DEF_DATA_W = 9;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_CNT_W  = 8;

    // Instruction word: {opcode[8:6], rd[5:4], rs0[3:2], rs1[1:0]}
    localparam int OP_W    = 3;
    localparam int INSTR_W = 9;
    localparam int OP_LSB  = 6;
    localparam int RD_LSB  = 4;
    localparam int RS0_LSB = 2;
    localparam int RS1_LSB = 0;

    // Opcodes; every encoding is legal
    localparam logic [OP_W-1:0] OP_NOP = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_OR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XOR = 3'b101;
    localparam logic [OP_W-1:0] OP_NOT = 3'b110;
    localparam logic [OP_W-1:0] OP_LDI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/rf_instr_dec.sv
// Opcode decoder for the sequencing controller.
// Ports:
//   op_i       opcode to decode
//   next_st_o  state entered from IDLE when this opcode is accepted
//   uses_rs1_o opcode reads the second source operand
//   is_ldi_o   write data comes from the immediate, not the ALU
module rf_instr_dec
    import rf_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output state_e          next_st_o,
    output logic            uses_rs1_o,
    output logic            is_ldi_o
);

    always_comb begin
        next_st_o  = ST_READ;
        uses_rs1_o = 1'b1;
        is_ldi_o   = 1'b0;
        case (op_i)
            OP_NOP: begin
                next_st_o  = ST_IDLE;
                uses_rs1_o = 1'b0;
            end
            OP_NOT: uses_rs1_o = 1'b0;
            OP_LDI: begin
                next_st_o  = ST_WRITE;
                uses_rs1_o = 1'b0;
                is_ldi_o   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rf_seq_ctrl.sv
// Sequencing controller for the 4 x 9-bit register file and its ALU.
// Takes one instruction at a time over valid/ready and walks it through
// READ -> EXEC -> WRITE (LDI skips straight to WRITE, NOP retires at once).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instr_valid/instr_ready   host handshake; instr/imm sampled on accept
//   alu_result                combinational ALU output for current rf data
//   rf_rd0_addr/rf_rd1_addr   register file read addresses
//   rf_wr_addr/en/data        register file write port
//   alu_op                    ALU operation select
//   busy, done, retired_cnt   status: in flight, retire pulse, retire count
module rf_seq_ctrl
    import rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [DATA_W-1:0]  imm,
    input  logic [DATA_W-1:0]  alu_result,
    output logic [ADDR_W-1:0]  rf_rd0_addr,
    output logic [ADDR_W-1:0]  rf_rd1_addr,
    output logic [ADDR_W-1:0]  rf_wr_addr,
    output logic               rf_wr_en,
    output logic [DATA_W-1:0]  rf_wr_data,
    output logic [OP_W-1:0]    alu_op,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   retired_cnt
);

    state_e              state_q;
    logic [INSTR_W-1:0]  instr_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   result_q;
    logic                done_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   rd0_hold_q, rd1_hold_q;

    logic [OP_W-1:0]     op_q;
    logic [ADDR_W-1:0]   rd_q, rs0_q, rs1_q;
    logic                rd_phase;

    // Decoder input: the incoming opcode while idle (to pick the next
    // state), the latched opcode while an instruction is in flight.
    logic [OP_W-1:0]     dec_op;
    state_e              dec_next_st;
    logic                dec_uses_rs1;
    logic                dec_is_ldi;

    assign op_q  = instr_q[OP_LSB  +: OP_W];
    assign rd_q  = instr_q[RD_LSB  +: ADDR_W];
    assign rs0_q = instr_q[RS0_LSB +: ADDR_W];
    assign rs1_q = instr_q[RS1_LSB +: ADDR_W];

    assign dec_op = (state_q == ST_IDLE) ? instr[OP_LSB +: OP_W] : op_q;

    rf_instr_dec u_dec (
        .op_i       (dec_op),
        .next_st_o  (dec_next_st),
        .uses_rs1_o (dec_uses_rs1),
        .is_ldi_o   (dec_is_ldi)
    );

    assign rd_phase = (state_q == ST_READ) || (state_q == ST_EXEC);
    assign cnt_d    = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            imm_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            rd0_hold_q <= '0;
            rd1_hold_q <= '0;
        end else begin
            done_q <= 1'b0;

            // Remember the last driven read addresses so they hold
            // outside READ/EXEC.
            if (rd_phase) rd0_hold_q <= rs0_q;
            if (rd_phase && dec_uses_rs1) rd1_hold_q <= rs1_q;

            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        imm_q   <= imm;
                        state_q <= dec_next_st;
                        // NOP retires on the accept edge itself
                        if (dec_next_st == ST_IDLE) begin
                            done_q <= 1'b1;
                            cnt_q  <= cnt_d;
                        end
                    end
                end
                ST_READ:  state_q <= ST_EXEC;
                ST_EXEC: begin
                    // rf read data became valid this cycle, so the ALU
                    // output reflects the real operands here.
                    result_q <= alu_result;
                    state_q  <= ST_WRITE;
                end
                ST_WRITE: begin
                    done_q  <= 1'b1;
                    cnt_q   <= cnt_d;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // All outputs below are pure decodes of registered state.
    assign instr_ready = (state_q == ST_IDLE);
    assign busy        = !instr_ready;
    assign done        = done_q;
    assign retired_cnt = cnt_q;

    assign rf_rd0_addr = rd_phase ? rs0_q : rd0_hold_q;
    assign rf_rd1_addr = (rd_phase && dec_uses_rs1) ? rs1_q : rd1_hold_q;

    assign rf_wr_en    = (state_q == ST_WRITE);
    assign rf_wr_addr  = rd_q;
    assign rf_wr_data  = !rf_wr_en ? '0 : (dec_is_ldi ? imm_q : result_q);

    assign alu_op      = (state_q == ST_IDLE) ? OP_NOP : op_q;

endmodule
